// File: rtl/interleaver_pingpong_ctrl_if.sv
// Handshake and bank-control bundle between the CRC attach stage, the ping-pong
// controller and the interleaver read path. The "slave" modport is the controller.
interface interleaver_pingpong_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic              block_size;
    logic              crc_start;
    logic              crc_data_valid;
    logic              crc_end;
    logic              in_ready;
    logic              out_ready;
    logic              ram0_we;
    logic              ram1_we;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_bank;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_count;
    logic              rd_valid;
    logic              rd_last;
    logic              ready;
    logic              done;
    logic [2:0]        state;

    // Input beat moves on crc_data_valid && in_ready; read beat moves on rd_en,
    // which is only raised while out_ready is high; rd_valid follows rd_en by one cycle.
    modport master (
        output block_size, crc_start, crc_data_valid, crc_end, out_ready,
        input  in_ready, ram0_we, ram1_we, wr_addr, rd_bank, rd_en, rd_count,
               rd_valid, rd_last, ready, done, state
    );

    modport slave (
        input  block_size, crc_start, crc_data_valid, crc_end, out_ready,
        output in_ready, ram0_we, ram1_we, wr_addr, rd_bank, rd_en, rd_count,
               rd_valid, rd_last, ready, done, state
    );
endinterface

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong bank controller for the turbo interleaver: one bank filled linearly while
// the other is read out. Optional sticky protocol-error flag under INTLV_PINGPONG_ERR_EN.
module interleaver_pingpong_ctrl #(
    parameter int ADDR_W    = 13,
    parameter int BLK_SMALL = 1056,
    parameter int BLK_LARGE = 6144
) (
    input  logic clk,
    input  logic reset_n,
`ifdef INTLV_PINGPONG_ERR_EN
    output logic err,
`endif
    interleaver_pingpong_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // One extra bit so a length of exactly 2^ADDR_W is representable.
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    function automatic logic [LEN_W-1:0] blk_len(input logic sel);
        return sel ? LEN_W'(BLK_LARGE) : LEN_W'(BLK_SMALL);
    endfunction

    state_t            state_q;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [LEN_W-1:0]  len_q [2];
    logic              rd_bank_q;
    logic              rd_busy;
    logic [ADDR_W-1:0] rd_count_q;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic              ready_q;
    logic              done_q;
    logic              end_seen;

    logic in_ready;
    logic accept;
    logic wr_done;
    logic rd_en;
    logic rd_done;
    logic rd_free;
    logic do_swap;
    logic do_drain;

    assign in_ready = (state_q == S_FILL) || (state_q == S_STREAM);
    assign accept   = bus.crc_data_valid && in_ready;
    assign wr_done  = accept &&
                      (({1'b0, wr_addr_q} == (len_q[wr_bank] - LEN_ONE)) || bus.crc_end);
    assign rd_en    = rd_busy && bus.out_ready;
    assign rd_done  = rd_en && ({1'b0, rd_count_q} == (len_q[rd_bank_q] - LEN_ONE));
    // The read bank is free when it has finished or finishes on this very edge.
    assign rd_free  = !rd_busy || rd_done;

    always_comb begin
        do_swap  = 1'b0;
        do_drain = 1'b0;
        case (state_q)
            S_FILL: begin
                if (wr_done) begin
                    do_swap  = !bus.crc_end;
                    do_drain = bus.crc_end;
                end
            end
            S_STREAM: begin
                if (wr_done && rd_free) begin
                    do_swap  = !bus.crc_end;
                    do_drain = bus.crc_end;
                end
            end
            S_WAIT: begin
                if (rd_done) begin
                    do_swap  = !end_seen;
                    do_drain = end_seen;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_bank    <= 1'b0;
            wr_addr_q  <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            rd_bank_q  <= 1'b0;
            rd_busy    <= 1'b0;
            rd_count_q <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            end_seen   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_last_q  <= rd_done;
            done_q     <= 1'b0;

            if (rd_en) begin
                rd_count_q <= rd_done ? '0 : rd_count_q + 1'b1;
            end
            if (rd_done) begin
                rd_busy <= 1'b0;
            end
            if (accept) begin
                wr_addr_q <= wr_addr_q + 1'b1;
            end
            // A crc_end beat shortens the block to what has actually been written.
            if (wr_done && bus.crc_end) begin
                len_q[wr_bank] <= {1'b0, wr_addr_q} + LEN_ONE;
            end

            if (do_swap) begin
                rd_bank_q       <= wr_bank;
                rd_busy         <= 1'b1;
                rd_count_q      <= '0;
                wr_bank         <= ~wr_bank;
                wr_addr_q       <= '0;
                len_q[~wr_bank] <= blk_len(bus.block_size);
            end
            if (do_drain) begin
                rd_bank_q  <= wr_bank;
                rd_busy    <= 1'b1;
                rd_count_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.crc_start) begin
                        state_q   <= S_FILL;
                        wr_bank   <= 1'b0;
                        wr_addr_q <= '0;
                        len_q[0]  <= blk_len(bus.block_size);
                        end_seen  <= 1'b0;
                        ready_q   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (do_drain) begin
                        state_q <= S_DRAIN;
                    end else if (do_swap) begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (do_drain) begin
                        state_q <= S_DRAIN;
                    end else if (wr_done && !do_swap) begin
                        state_q  <= S_WAIT;
                        end_seen <= bus.crc_end;
                    end
                end
                S_WAIT: begin
                    if (do_drain) begin
                        state_q <= S_DRAIN;
                    end else if (do_swap) begin
                        state_q <= S_STREAM;
                    end
                end
                S_DRAIN: begin
                    if (rd_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef INTLV_PINGPONG_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if ((bus.crc_data_valid && !in_ready && (state_q != S_IDLE)) ||
                     (bus.crc_end && !bus.crc_data_valid) ||
                     (bus.crc_start && (state_q != S_IDLE))) begin
            err <= 1'b1;
        end
    end
`endif

    assign bus.in_ready = in_ready;
    assign bus.ram0_we  = accept && !wr_bank;
    assign bus.ram1_we  = accept && wr_bank;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.rd_en    = rd_en;
    assign bus.rd_count = rd_count_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Bench for interleaver_pingpong_ctrl: frame-level vector table, directed reset and
// WAIT sequences, and randomized frames scored against a block-list reference model.
module tb_interleaver_pingpong_ctrl;
    localparam int ADDR_W    = 4;
    localparam int BLK_SMALL = 8;
    localparam int BLK_LARGE = 16;
    localparam int RW        = ADDR_W + 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic abort = 1'b0;
    logic mon_en = 1'b0;
    int   or_mode = 0;

    always #5 clk = ~clk;

    interleaver_pingpong_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef INTLV_PINGPONG_ERR_EN
    logic err;
`endif

    interleaver_pingpong_ctrl #(
        .ADDR_W(ADDR_W), .BLK_SMALL(BLK_SMALL), .BLK_LARGE(BLK_LARGE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef INTLV_PINGPONG_ERR_EN
        .err(err),
`endif
        .bus(bus)
    );

    // Scoreboard: expected write beats {bank, addr} and read beats {bank, count, last}.
    logic [ADDR_W:0] wr_exp_q[$];
    logic [RW-1:0]   rd_exp_q[$];
    logic            pend_v = 1'b0;
    logic            pend_last = 1'b0;
    int              rv_cnt = 0;
    int              wait_cyc = 0;
    logic            stream_seen = 1'b0;

    typedef struct {
        int       nblk;
        logic [7:0] bs;
        int       trunc;
        int       orm;
        int       exp_beats;
        int       exp_wait;
        int       exp_stream;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no matching event, required one at %0t", name, $time);
    endtask

    task automatic check_reset(input string name);
        chk(name, {bus.in_ready, bus.ram0_we, bus.ram1_we, bus.wr_addr, bus.rd_bank, bus.rd_en,
                   bus.rd_count, bus.rd_valid, bus.rd_last, bus.ready, bus.done, bus.state},
            32'h10);
`ifdef INTLV_PINGPONG_ERR_EN
        chk({name, "_err"}, err, 0);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ~bus.out_ready;
                2: bus.out_ready = ($urandom_range(0, 9) < 7);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        logic [RW-1:0]   r;
        logic [ADDR_W:0] w;
        if (!mon_en) begin
            pend_v = 1'b0;
        end else begin
            chk("in_ready_vs_state", bus.in_ready, (bus.state == 3'd1) || (bus.state == 3'd2));
            if (bus.crc_data_valid && bus.in_ready) begin
                if (wr_exp_q.size() == 0) begin
                    fail("wr_unexpected");
                end else begin
                    w = wr_exp_q.pop_front();
                    chk("wr_bank_addr", {bus.ram1_we, bus.ram0_we, bus.wr_addr},
                        {w[ADDR_W], ~w[ADDR_W], w[ADDR_W-1:0]});
                end
            end else begin
                chk("wr_idle_we", {bus.ram1_we, bus.ram0_we}, 0);
            end
            if (pend_v) begin
                chk("rd_valid", bus.rd_valid, 1);
                chk("rd_last", bus.rd_last, pend_last);
                rv_cnt++;
            end else begin
                chk("rd_valid_idle", bus.rd_valid, 0);
            end
            pend_v = 1'b0;
            if (bus.rd_en) begin
                chk("rd_en_gated", bus.out_ready, 1);
                if (rd_exp_q.size() == 0) begin
                    fail("rd_unexpected");
                end else begin
                    r = rd_exp_q.pop_front();
                    chk("rd_bank_count", {bus.rd_bank, bus.rd_count}, r[RW-1:1]);
                    pend_v    = 1'b1;
                    pend_last = r[0];
                end
            end
            if (bus.state == 3'd3) wait_cyc++;
            if (bus.state == 3'd2) stream_seen = 1'b1;
        end
    end

    task automatic send_beat(input logic e, input logic bsz, input bit gaps);
        int t;
        bus.block_size = bsz;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        bus.crc_data_valid = 1'b1;
        bus.crc_end        = e;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            fail("in_ready_timeout");
            abort = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.crc_data_valid = 1'b0;
        bus.crc_end        = 1'b0;
    endtask

    task automatic start_frame(input logic bsz);
        @(posedge clk);
        #1;
        bus.block_size = bsz;
        bus.crc_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.crc_start  = 1'b0;
    endtask

    // Reference model: a frame is a list of blocks on alternating banks 0,1,0,...;
    // every block is full length except the last, cut at the crc_end beat.
    task automatic run_frame(input int nblk, input logic [7:0] bs, input int trunc, input bit gaps);
        int len;
        int t;
        logic [ADDR_W-1:0] av;
        rv_cnt      = 0;
        wait_cyc    = 0;
        stream_seen = 1'b0;
        for (int k = 0; k < nblk; k++) begin
            len = (k == nblk - 1) ? trunc : (bs[k] ? BLK_LARGE : BLK_SMALL);
            for (int a = 0; a < len; a++) begin
                av = ADDR_W'(a);
                wr_exp_q.push_back({k[0], av});
                rd_exp_q.push_back({k[0], av, (a == len - 1)});
            end
        end
        start_frame(bs[0]);
        for (int k = 0; k < nblk && !abort; k++) begin
            len = (k == nblk - 1) ? trunc : (bs[k] ? BLK_LARGE : BLK_SMALL);
            for (int a = 0; a < len && !abort; a++) begin
                send_beat((k == nblk - 1) && (a == len - 1),
                          ((a == len - 1) && (k < nblk - 1)) ? bs[k + 1] : bs[k], gaps);
            end
        end
        if (!abort) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.done && t < 4000);
            if (!bus.done) begin
                fail("done_timeout");
                abort = 1'b1;
            end else begin
                chk("done_state", bus.state, 5);
                @(negedge clk);
                chk("idle_after_done", {bus.ready, bus.done, bus.state}, 32'h10);
                chk("rd_q_drained", rd_exp_q.size(), 0);
                chk("wr_q_drained", wr_exp_q.size(), 0);
            end
        end
        rd_exp_q.delete();
        wr_exp_q.delete();
    endtask

    initial begin
        vec_t vecs[6];
        int   nblk;
        logic [7:0] bs;
        int   trunc;
        vecs[0] = '{1, 8'h00, 8,  0, 8,  0, 0};
        vecs[1] = '{3, 8'h07, 16, 0, 48, 0, 1};
        vecs[2] = '{3, 8'h07, 16, 1, 48, 1, 1};
        vecs[3] = '{1, 8'h01, 5,  0, 5,  0, 0};
        vecs[4] = '{2, 8'h01, 8,  0, 24, 1, 1};
        vecs[5] = '{2, 8'h00, 3,  0, 11, 1, 1};

        bus.block_size     = 1'b0;
        bus.crc_start      = 1'b0;
        bus.crc_data_valid = 1'b0;
        bus.crc_end        = 1'b0;
        bus.out_ready      = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_values");
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 6 && !abort; i++) begin
            or_mode = vecs[i].orm;
            run_frame(vecs[i].nblk, vecs[i].bs, vecs[i].trunc, 1'b0);
            chk("vec_read_beats", rv_cnt, vecs[i].exp_beats);
            chk("vec_wait_seen", (wait_cyc > 0), vecs[i].exp_wait);
            chk("vec_stream_seen", stream_seen, vecs[i].exp_stream);
        end

        // Asynchronous reset in the middle of STREAM, then a clean frame.
        if (!abort) begin
            mon_en  = 1'b0;
            or_mode = 0;
            start_frame(1'b1);
            for (int i = 0; i < 20 && !abort; i++) send_beat(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            chk("pre_reset_stream", bus.state, 2);
            #2;
            reset_n = 1'b0;
            #1;
            check_reset("async_reset");
            @(negedge clk);
            reset_n = 1'b1;
            mon_en  = 1'b1;
            run_frame(1, 8'h00, 8, 1'b0);
            chk("post_reset_beats", rv_cnt, 8);
        end

        // Beat offered while in WAIT: must not be written, and flags err when present.
        if (!abort) begin
            mon_en  = 1'b0;
            or_mode = 3;
            start_frame(1'b0);
            for (int i = 0; i < 16 && !abort; i++) send_beat(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk("wait_entered", {bus.in_ready, bus.state}, 3);
            bus.crc_data_valid = 1'b1;
            #1;
            chk("wait_beat_no_we", {bus.ram1_we, bus.ram0_we}, 0);
            @(posedge clk);
            #1;
            bus.crc_data_valid = 1'b0;
            @(negedge clk);
            chk("wait_beat_ignored", {bus.state, bus.wr_addr}, {3'd3, 4'd8});
`ifdef INTLV_PINGPONG_ERR_EN
            chk("err_set", err, 1);
            repeat (3) @(negedge clk);
            chk("err_sticky", err, 1);
`endif
            reset_n = 1'b0;
            #1;
            check_reset("reset_after_wait");
            @(negedge clk);
            reset_n = 1'b1;
            mon_en  = 1'b1;
        end

        for (int f = 0; f < 12 && !abort; f++) begin
            nblk    = $urandom_range(1, 4);
            bs      = 8'($urandom);
            trunc   = $urandom_range(1, bs[nblk - 1] ? BLK_LARGE : BLK_SMALL);
            or_mode = $urandom_range(0, 2);
            run_frame(nblk, bs, trunc, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/interleaver_pingpong_ctrl.md
# interleaver_pingpong_ctrl

Parametrised ping-pong controller for the turbo interleaver datapath. Two block RAM banks alternate roles: one bank is written linearly from the CRC stage while the other is read out by the interleaved-address path. The controller supports two configurable block lengths, truncated final blocks, and backpressure on both the input and output sides. It sits between the CRC attach stage and the interleaver address generator / RAM pair.

## Interface
- ADDR_W, 13: bank address width; must satisfy 2^ADDR_W ≥ BLK_LARGE.
- BLK_SMALL, 1056: block length in bits when `block_size`=0.
- BLK_LARGE, 6144: block length in bits when `block_size`=1.
---
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- block_size  in  1  length select; sampled at block start.
- crc_start  in  1  start-of-frame pulse; honoured only in IDLE.
- crc_data_valid  in  1  input beat present.
- crc_end  in  1  qualifies the final beat of the frame; valid only together with crc_data_valid.
- in_ready  out  1  beat accepted when crc_data_valid && in_ready.
- out_ready  in  1  downstream can take a read beat.
- ram0_we, ram1_we  out  1  per-bank write enable; at most one is high.
- wr_addr  out  ADDR_W  linear write address.
- rd_bank  out  1  bank being read.
- rd_en  out  1  read strobe, equals rd_active && out_ready.
- rd_count  out  ADDR_W  linear read index, fed to the interleaver address generator.
- rd_valid  out  1  read data valid, one cycle after rd_en.
- rd_last  out  1  rd_valid beat is the last beat of its block.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse at frame completion.
- state  out  3  current FSM state, for debug.

## Operation
- States:
  - IDLE=0
  - FILL=1: write only
  - STREAM=2: write one bank, read the other
  - WAIT=3: write block complete, read still busy
  - DRAIN=4: read only
  - DONE=5
- Per-bank length register `len[b]`, loaded at block start: BLK_SMALL or BLK_LARGE per `block_size`.
- Write side:
  - On an accepted beat: drive `ramX_we` for the write bank at `wr_addr`, then increment `wr_addr`.
  - The block completes when the beat at `wr_addr` = `len`−1 is accepted.
  - The block also completes on an accepted beat with `crc_end` high; in that case `len[wr_bank]` := `wr_addr`+1 (truncation).
- Read side:
  - `rd_count` runs from 0 to `len[rd_bank]`−1, advancing only on `rd_en`.
  - Read completes on the `rd_en` with `rd_count` = `len`−1.
- Transitions:
  - IDLE→FILL on `crc_start`: `wr_bank`=0, `wr_addr`=0, load `len[0]`.
  - FILL, on write-complete: if not a `crc_end` beat → STREAM, swapping banks and loading the new `len`; if a `crc_end` beat → DRAIN.
  - STREAM, on write-complete while the read is done, or completing in the same cycle → swap, stay in STREAM.
  - STREAM, on write-complete while the read is still busy → WAIT; `in_ready` is low throughout WAIT.
  - WAIT, on read-complete → STREAM, then swap.
  - On a write-complete caused by `crc_end` (from STREAM or WAIT): once the pending read finishes → DRAIN on the last bank.
  - DRAIN, on read-complete → DONE.
  - DONE → IDLE, with `done`=1 for that cycle.
- Simultaneous events:
  - Write-complete and read-complete in the same cycle → immediate swap, no WAIT.
  - `crc_start` outside IDLE is ignored.
  - `crc_data_valid` in IDLE or DRAIN is ignored.
- Reset mid-operation returns to IDLE and discards bank contents.

## Timing
- Reset values:
  - `in_ready`=0, `ram0_we`=`ram1_we`=0, `wr_addr`=0
  - `rd_bank`=0, `rd_en`=0, `rd_count`=0, `rd_valid`=0, `rd_last`=0
  - `ready`=1, `done`=0, `state`=0
- Write enables and `wr_addr` are combinational from the accepted beat (same-cycle write).
- `in_ready` is combinational from the registered state: high in FILL and STREAM only.
- `rd_valid` and `rd_last` are registered: exactly 1-cycle latency from `rd_en`.
- First read of a bank is at the earliest one cycle after the swap edge.
- `rd_count` width arithmetic is unsigned modulo 2^ADDR_W; no wrap occurs within legal lengths.

## Configuration
- `INTLV_PINGPONG_ERR_EN` defined:
  - Adds output `err` (1 bit, reset 0, sticky until reset).
  - `err` is set by `crc_data_valid` while `in_ready`=0 outside IDLE, by `crc_end` without `crc_data_valid`, or by `crc_start` outside IDLE.
- Undefined: the `err` port is absent and these events are silently ignored.

## Test plan
- BLK_SMALL=8, BLK_LARGE=16, `block_size`=0, one frame of 8 beats with `crc_end` on beat 8, `out_ready`=1 → FILL→DRAIN, 8 `rd_valid` beats on bank 0 with `rd_last` on `rd_count`=7, `done` pulse, back to IDLE.
- 3 blocks of 16 beats, continuous input, `out_ready`=1 → bank sequence 0,1,0; reads overlap writes; `in_ready` never drops.
- Same as previous but `out_ready` toggled 1/0 → WAIT entered, `in_ready`=0 until read-complete, no beat lost, read order preserved.
- `crc_end` on beat 5 of a 16-beat block → `len`=5, exactly 5 read beats with `rd_last` on the 5th, then DONE.
- `reset_n` low mid-STREAM → all outputs at reset values asynchronously; a subsequent `crc_start` runs a clean frame.
- With `INTLV_PINGPONG_ERR_EN`: beat driven during WAIT → `err`=1 the next cycle and held; without the macro, same stimulus gives identical read-side output.
